// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [XLEN-1:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_HALT} ifu_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } if_id_t;

  // Zero-filled memory is treated like EBREAK so a runaway PC parks itself.
  function automatic logic is_halt_instr(input logic [XLEN-1:0] instr);
    return (instr == INSTR_EBREAK) || (instr == '0);
  endfunction
endpackage

// File: rtl/instr_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush clears valid only, load captures, otherwise hold.
module if_id_reg
  import instr_fetch_unit_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   load_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);
  if_id_t q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '{valid: 1'b0, pc: '0, pc_plus4: '0, instr: INSTR_NOP};
    end else if (flush_i) begin
      q_q.valid <= 1'b0;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, boot delay, stall/redirect handling and halt on EBREAK.
// Optional perf counters are built when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              BOOT_CYCLES = 2
) (
  input  logic            SYS_clk,
  input  logic            SYS_reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [XLEN-1:0] if_id_instr,
  output logic            halted
`ifdef IFU_PERF_CNT_EN
  , output logic [31:0]   perf_fetched
  , output logic [31:0]   perf_bubbles
`endif
);
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      boot_cnt_q, boot_cnt_d;
  logic            ld, fl;
  logic [XLEN-1:0] tgt;
  logic            unused_tgt_bits;
  if_id_t          ifid_d, ifid_q;

  assign tgt             = {redirect_target[XLEN-1:2], 2'b00};
  assign unused_tgt_bits = ^redirect_target[1:0];

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      boot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  if (boot_cnt_q == BOOT_LAST) state_d = ST_FETCH;
      ST_FETCH: if (!redirect_valid && !stall && is_halt_instr(imem_rdata)) state_d = ST_HALT;
      ST_HALT:  if (redirect_valid) state_d = ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    boot_cnt_d = boot_cnt_q;
    ld         = 1'b0;
    fl         = 1'b0;
    case (state_q)
      ST_BOOT: boot_cnt_d = boot_cnt_q + 4'd1;
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_d = tgt;
          fl   = 1'b1;
        end else if (!stall) begin
          ld = 1'b1;
          if (!is_halt_instr(imem_rdata)) pc_d = pc_q + 32'd4;
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          pc_d = tgt;
          fl   = 1'b1;
        end else if (!stall) begin
          fl = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ifid_d = '{valid: 1'b1, pc: pc_q, pc_plus4: pc_q + 32'd4, instr: imem_rdata};

  if_id_reg u_if_id (
    .clk_i   (SYS_clk),
    .rst_i   (SYS_reset),
    .load_i  (ld),
    .flush_i (fl),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign imem_addr      = pc_q;
  assign if_id_valid    = ifid_q.valid;
  assign if_id_pc       = ifid_q.pc;
  assign if_id_pc_plus4 = ifid_q.pc_plus4;
  assign if_id_instr    = ifid_q.instr;
  assign halted         = (state_q == ST_HALT);

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetched_q, bubbles_q;
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      if (ld) fetched_q <= fetched_q + 32'd1;
      if (state_q != ST_BOOT && (stall || redirect_valid)) bubbles_q <= bubbles_q + 32'd1;
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a cycle-level behavioural model.
module tb_instr_fetch_unit;
  logic        SYS_clk = 1'b0;
  logic        SYS_reset;
  logic        stall, redirect_valid;
  logic [31:0] redirect_target, imem_addr, imem_rdata;
  logic        if_id_valid, halted;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  logic [31:0] mem [0:127];
  assign imem_rdata = mem[imem_addr[8:2]];

  instr_fetch_unit dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
    .halted(halted)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 SYS_clk = ~SYS_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: counts down the boot delay, then applies redirect > stall > fetch.
  int          m_boot;
  logic        m_halt, m_v;
  logic [31:0] m_pc, m_ipc, m_ipc4, m_ins, m_pf, m_pb, ins;

  always @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      m_boot = 2; m_halt = 0; m_v = 0; m_pc = 0;
      m_ipc = 0; m_ipc4 = 0; m_ins = 32'h13; m_pf = 0; m_pb = 0;
    end else if (m_boot > 0) begin
      m_boot--;
    end else begin
      if (stall || redirect_valid) m_pb++;
      if (redirect_valid) begin
        m_pc = redirect_target & ~32'd3; m_v = 0; m_halt = 0;
      end else if (!stall) begin
        if (m_halt) m_v = 0;
        else begin
          ins = mem[m_pc[8:2]];
          m_v = 1; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_ins = ins; m_pf++;
          if (ins == 32'h0010_0073 || ins == 32'h0) m_halt = 1;
          else m_pc = m_pc + 4;
        end
      end
    end
  end

  always @(negedge SYS_clk) begin
    if (!SYS_reset) begin
      chk("m_addr", imem_addr, m_pc);
      chk("m_valid", {31'd0, if_id_valid}, {31'd0, m_v});
      chk("m_pc", if_id_pc, m_ipc);
      chk("m_pc4", if_id_pc_plus4, m_ipc4);
      chk("m_instr", if_id_instr, m_ins);
      chk("m_halted", {31'd0, halted}, {31'd0, m_halt});
`ifdef IFU_PERF_CNT_EN
      chk("m_perf_f", perf_fetched, m_pf);
      chk("m_perf_b", perf_bubbles, m_pb);
`endif
    end
  end

  task automatic tick();
    @(posedge SYS_clk); #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    chk({nm, "_pc"}, if_id_pc, 32'd0);
    chk({nm, "_pc4"}, if_id_pc_plus4, 32'd0);
    chk({nm, "_instr"}, if_id_instr, 32'h13);
    chk({nm, "_halted"}, {31'd0, halted}, 32'd0);
    chk({nm, "_addr"}, imem_addr, 32'd0);
  endtask

  initial begin
    SYS_reset = 1; stall = 0; redirect_valid = 0; redirect_target = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013;
    mem[4]  = 32'h0010_0073;  // 0x10: EBREAK
    mem[16] = 32'h0010_0113;  // 0x40
    mem[64] = 32'h0050_0093;  // 0x100

    tick();
    chk_reset("rst");
    SYS_reset = 0;
    tick(); tick();
    chk("boot_no_valid", {31'd0, if_id_valid}, 32'd0);
    tick();  // posedge 3
    chk("first_valid", {31'd0, if_id_valid}, 32'd1);
    chk("first_pc", if_id_pc, 32'h0);
    tick();
    chk("second_pc", if_id_pc, 32'h4);
    chk("second_pc4", if_id_pc_plus4, 32'h8);

    stall = 1; tick(); tick(); tick(); stall = 0;
    chk("stall_addr", imem_addr, 32'h8);
    chk("stall_pc", if_id_pc, 32'h4);
    tick();
    chk("resume_pc", if_id_pc, 32'h8);
    tick(); tick();
    chk("ebreak_valid", {31'd0, if_id_valid}, 32'd1);
    chk("ebreak_pc", if_id_pc, 32'h10);
    chk("ebreak_halted", {31'd0, halted}, 32'd1);
    chk("ebreak_addr", imem_addr, 32'h10);
    tick();
    chk("halt_valid", {31'd0, if_id_valid}, 32'd0);
    chk("halt_addr", imem_addr, 32'h10);

    redirect_valid = 1; redirect_target = 32'h40; tick(); redirect_valid = 0;
    chk("unhalt_halted", {31'd0, halted}, 32'd0);
    chk("unhalt_addr", imem_addr, 32'h40);
    tick();
    chk("tgt40_pc", if_id_pc, 32'h40);
    chk("tgt40_instr", if_id_instr, 32'h0010_0113);

    redirect_valid = 1; stall = 1; redirect_target = 32'h103; tick();
    redirect_valid = 0; stall = 0;
    chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
    tick();
    chk("tgt100_valid", {31'd0, if_id_valid}, 32'd1);
    chk("tgt100_instr", if_id_instr, 32'h0050_0093);

    redirect_valid = 1; redirect_target = 32'h20; tick(); redirect_valid = 0;
    tick();
    chk("pre_reset_addr", imem_addr, 32'h24);
    #1 SYS_reset = 1;
    #1 chk_reset("async_rst");

    // Redirect during boot must be ignored; then 5 fetches, 2 stalls, 1 redirect.
    tick();
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFF; SYS_reset = 0;
    tick(); tick(); redirect_valid = 0;
    chk("boot_ignore_redir", imem_addr, 32'h0);
    tick(); tick(); tick();
    stall = 1; tick(); tick(); stall = 0;
    tick();
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC; tick(); redirect_valid = 0;
    tick();
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc_plus4, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'd5);
    chk("perf_bubbles", perf_bubbles, 32'd3);
`endif
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front-end fetch stage of the RISC-V core, directly upstream of the instruction memory. Owns the program counter, drives the word address into instruction memory, and captures the returned instruction together with its PC into the IF/ID pipeline register. Handles the stall, redirect (branch/jump flush), boot delay after reset, and halt-on-EBREAK behaviour. Downstream, the decode stage consumes the IF/ID outputs.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BOOT_CYCLES, 2, cycles after reset release before the first fetch; range 1..15.
- SYS_clk  in  1  single clock; all state changes on posedge.
- SYS_reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC and the IF/ID register this cycle.
- redirect_valid  in  1  flush the fetch stage and load a new PC.
- redirect_target  in  32  new PC; bits [1:0] are ignored (forced to 0).
- imem_addr  out  32  byte address to instruction memory; combinationally equals pc_q.
- imem_rdata  in  32  instruction returned combinationally for imem_addr.
- if_id_valid  out  1  IF/ID register holds a live instruction.
- if_id_pc  out  32  PC of the captured instruction.
- if_id_pc_plus4  out  32  if_id_pc + 4, modulo 2^32.
- if_id_instr  out  32  captured instruction.
- halted  out  1  high while in HALT.

## Operation
- FSM states: BOOT, FETCH, HALT.
- Reset (asynchronous): state=BOOT, pc_q=RESET_PC, boot counter=0, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=0, if_id_instr=32'h0000_0013 (NOP), halted=0.
- BOOT: the counter increments each cycle. When the counter reaches BOOT_CYCLES-1, the FSM moves to FETCH. stall and redirect are ignored. No capture occurs.
- FETCH, priority redirect > stall > normal:
  - Redirect: pc_q <= {redirect_target[31:2],2'b00}; if_id_valid <= 0. Applies even with stall asserted.
  - Stall: all registers hold.
  - Normal: IF/ID <= {pc_q, pc_q+4, imem_rdata}; if_id_valid <= 1; pc_q <= pc_q+4, wrapping 32'hFFFF_FFFC -> 0.
  - Halt detect (normal capture only): if imem_rdata == 32'h0010_0073 (EBREAK) or 32'h0000_0000 (zero-filled memory), the instruction is still captured valid, pc_q holds, and the FSM moves to HALT.
- HALT: halted=1; pc_q holds.
  - Non-stalled cycle: if_id_valid <= 0.
  - Redirect: treated as a wrong-path halt. pc_q <= target, if_id_valid <= 0, FSM returns to FETCH, halted drops the next cycle.
  - Stall alone: everything holds.
- Reset mid-operation aborts any state immediately and returns to BOOT.

## Timing
- Memory read is combinational. The instruction at pc_q is captured at the same posedge that advances pc_q, so fetch latency is 1 cycle from PC to if_id_*.
- The first valid instruction appears BOOT_CYCLES+1 posedges after reset release.
- Redirect penalty: the cycle after redirect shows if_id_valid=0. The target instruction is valid on the following cycle.
- Throughput: one instruction per cycle when unstalled.
- All outputs except imem_addr are registered.

## Configuration
- IFU_PERF_CNT_EN defined:
  - Adds outputs perf_fetched (32-bit) and perf_bubbles (32-bit), both reset to 0 and wrapping at 2^32.
  - perf_fetched increments on every valid capture.
  - perf_bubbles increments on every FETCH/HALT cycle in which stall or redirect is asserted.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package contents:
  - FSM state enum (BOOT/FETCH/HALT).
  - INSTR_NOP = 32'h0000_0013.
  - INSTR_EBREAK = 32'h0010_0073.
  - XLEN = 32.
  - IF/ID bundle struct {valid, pc, pc_plus4, instr}.
- Sub-module if_id_reg: the IF/ID pipeline register, with load, flush and hold controls driven by the FSM. The PC, boot counter and FSM stay in the top.

## Test plan
- Reset release, memory holding 0x00000013 at 0x0 and 0x4, BOOT_CYCLES=2 -> if_id_valid rises on posedge 3 with if_id_pc=0x0; next cycle if_id_pc=0x4, if_id_pc_plus4=0x8.
- stall held 3 cycles while pc_q=0x8 -> imem_addr stays 0x8, if_id_* unchanged; capture of 0x8 resumes on the first unstalled edge.
- redirect_valid with target 0x103 asserted together with stall -> next cycle if_id_valid=0 and imem_addr=0x100; the instruction at 0x100 is valid one cycle later.
- EBREAK at 0x10 -> captured valid with if_id_pc=0x10, halted=1; if_id_valid=0 on the next cycle; imem_addr stays 0x10. A subsequent redirect to 0x40 -> halted=0 and fetch resumes at 0x40.
- SYS_reset asserted asynchronously mid-stream at pc_q=0x24 -> outputs immediately return to reset values and imem_addr=RESET_PC.
- With IFU_PERF_CNT_EN defined, 5 fetches, 2 stall cycles and 1 redirect -> perf_fetched=5, perf_bubbles=3.
